ddr3_req_arbiter: RTL and testbench
===================================

// Module: ddr3_req_arbiter
// PURPOSE
//  Multi-port successor to the single-AXI-port request path: arbitrates PORTS independent
//  request channels (each from its own AXI-side controller) onto the single write/read
//  request interface of ddr3_fsm. One transaction is outstanding at a time. The FSM tag is
//  formed as {port index, port tid}. Selectable round-robin or read-priority mode.
// PARAMETERS
//  PORTS         4   number of requesting channels (>=2)
//  DDR_ROW_BITS  15  row address width
//  DDR_COL_BITS  10  column address width; ASB = DDR_ROW_BITS+DDR_COL_BITS-1
//  AXI_ID_WIDTH  4   per-port transaction ID width
//  RD_PRIORITY   0   0: round-robin over all ports; 1: pending reads beat pending writes
//  AGE_LIMIT     8   max read grants while a write waits (only with ARB_AGE_LIMIT_EN)
//  (local) PSB = $clog2(PORTS)-1; MEM_ID_WIDTH = AXI_ID_WIDTH+PSB+1
// PORTS
//  clock        in   1                 system clock; all logic on rising edge
//  reset        in   1                 synchronous, active-high
//  req_valid_i  in   PORTS             per-port request, held until ack/err seen
//  req_write_i  in   PORTS             1=write, 0=read
//  req_tid_i    in   PORTS*AXI_ID_WIDTH  per-port ID, port p at [p*W +: W]
//  req_adr_i    in   PORTS*(ASB+1)     per-port DDR address
//  req_ack_o    out  PORTS             one-cycle completion pulse
//  req_err_o    out  PORTS             one-cycle error pulse
//  mem_wrreq_o  out  1                 write request to ddr3_fsm
//  mem_wrack_i  in   1  / mem_wrerr_i in 1
//  mem_wrtid_o  out  MEM_ID_WIDTH      {port, tid}
//  mem_wradr_o  out  ASB+1
//  mem_rdreq_o  out  1                 read request to ddr3_fsm
//  mem_rdack_i  in   1  / mem_rderr_i in 1
//  mem_rdtid_o  out  MEM_ID_WIDTH  /  mem_rdadr_o out ASB+1
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, rr pointer = PORTS-1 (port 0 wins first), age count 0.
//  FSM states: IDLE -> BUSY -> DONE -> IDLE.
//  IDLE: if any req_valid_i, pick winner, register tid/adr/type, raise mem_wrreq_o or
//   mem_rdreq_o (registered: visible cycle after sampling); rr pointer <= winner; go BUSY.
//  BUSY: mem_*req_o, tid, adr held stable. On matching mem_*ack_i or mem_*err_i: drop
//   mem_*req_o next cycle, pulse req_ack_o[win] (or req_err_o[win] if err; err wins if both)
//   in that same next cycle; go DONE. Acks on the non-active channel ignored.
//  DONE: one cycle, no arbitration (port drops req_valid_i after seeing pulse); -> IDLE.
//  Min turnaround: 3 cycles per transaction with zero-latency FSM ack.
//  Round-robin: search ports ptr+1..ptr+PORTS modulo PORTS; first valid wins.
//  RD_PRIORITY=1: round-robin among valid reads; writes considered only if no read valid.
//  Port withdrawing req_valid_i before grant: legal; after grant: ignored until DONE.
//  Reset mid-operation: returns to reset state next edge; in-flight request abandoned,
//   no ack/err pulse (ddr3_fsm shares the same reset).
//  tid packing: mem_*tid_o = {win[PSB:0], req_tid_i[win]}; unused port codes never produced.
// CONFIGURATION
//  ARB_AGE_LIMIT_EN defined: counter increments per read grant while any write is valid,
//   clears on a write grant or when no write valid; at AGE_LIMIT next grant is the
//   round-robin write winner regardless of reads. Undefined: no counter, pure policy
//   above (RD_PRIORITY=1 may starve writes indefinitely). No effect when RD_PRIORITY=0.
// STRUCTURE
//  Shared package ddr3_arb_pkg: state encodings (ST_IDLE/ST_BUSY/ST_DONE), tid-pack
//   function, PSB/MEM_ID_WIDTH derivation.
//  Sub-module ddr3_rr_pick: rotating-priority encoder (mask, ptr -> one-hot + index).
//   Instantiated twice (all-ports mask, write-only mask).
// TESTING
//  T1: port0 write adr 0x12345 tid 3 -> mem_wrreq_o next cycle, wrtid={0,3}; ack after 4
//      cycles -> req_ack_o=4'b0001 one cycle, mem_wrreq_o low same cycle.
//  T2: all 4 ports read, FSM acks immediately -> grant order 0,1,2,3,0; 3 cycles apart.
//  T3: RD_PRIORITY=1, port1 write + ports 0,2 reads held -> no write grant while reads
//      pending; with ARB_AGE_LIMIT_EN, AGE_LIMIT=4 -> write granted after 4th read.
//  T4: port2 read, mem_rderr_i pulse -> req_err_o=4'b0100, req_ack_o stays 0.
//  T5: reset while mem_wrreq_o high -> all outputs 0 next edge; next grant goes to port 0.
//  T6: stray mem_rdack_i during write BUSY -> ignored, no pulse, write still completes.

Source files
------------

// File: rtl/ddr3_arb_pkg.sv
// Shared definitions for the ddr3 request arbiter: FSM state encoding,
// port/tag width derivation and the {port, tid} tag packing helper.
package ddr3_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } arb_state_e;

    function automatic int calc_psb(input int ports);
        return $clog2(ports) - 1;
    endfunction

    function automatic int calc_mem_id_width(input int ports, input int id_w);
        return id_w + calc_psb(ports) + 1;
    endfunction

    // Tag seen by ddr3_fsm: port index in the upper bits, port-local tid below.
    function automatic logic [63:0] pack_tid(input logic [31:0] port,
                                             input logic [31:0] tid,
                                             input int          id_w);
        logic [63:0] tid_m;
        tid_m = {32'd0, tid} & ((64'd1 << id_w) - 64'd1);
        return ({32'd0, port} << id_w) | tid_m;
    endfunction

endpackage

// File: rtl/ddr3_req_arbiter_if.sv
// Bundle of the per-port request channels and the ddr3_fsm request interface.
// slave: the arbiter's view; master: requesting controllers plus ddr3_fsm.
interface ddr3_req_arbiter_if
    import ddr3_arb_pkg::*;
#(
    parameter int PORTS        = 4,
    parameter int DDR_ROW_BITS = 15,
    parameter int DDR_COL_BITS = 10,
    parameter int AXI_ID_WIDTH = 4
);
    localparam int ADR_W        = DDR_ROW_BITS + DDR_COL_BITS;
    localparam int MEM_ID_WIDTH = calc_mem_id_width(PORTS, AXI_ID_WIDTH);

    logic [PORTS-1:0]              req_valid_i;
    logic [PORTS-1:0]              req_write_i;
    logic [PORTS*AXI_ID_WIDTH-1:0] req_tid_i;
    logic [PORTS*ADR_W-1:0]        req_adr_i;
    logic [PORTS-1:0]              req_ack_o;
    logic [PORTS-1:0]              req_err_o;
    logic                          mem_wrreq_o;
    logic                          mem_wrack_i;
    logic                          mem_wrerr_i;
    logic [MEM_ID_WIDTH-1:0]       mem_wrtid_o;
    logic [ADR_W-1:0]              mem_wradr_o;
    logic                          mem_rdreq_o;
    logic                          mem_rdack_i;
    logic                          mem_rderr_i;
    logic [MEM_ID_WIDTH-1:0]       mem_rdtid_o;
    logic [ADR_W-1:0]              mem_rdadr_o;

    modport slave (
        input  req_valid_i, req_write_i, req_tid_i, req_adr_i,
        input  mem_wrack_i, mem_wrerr_i, mem_rdack_i, mem_rderr_i,
        output req_ack_o, req_err_o,
        output mem_wrreq_o, mem_wrtid_o, mem_wradr_o,
        output mem_rdreq_o, mem_rdtid_o, mem_rdadr_o
    );

    modport master (
        output req_valid_i, req_write_i, req_tid_i, req_adr_i,
        output mem_wrack_i, mem_wrerr_i, mem_rdack_i, mem_rderr_i,
        input  req_ack_o, req_err_o,
        input  mem_wrreq_o, mem_wrtid_o, mem_wradr_o,
        input  mem_rdreq_o, mem_rdtid_o, mem_rdadr_o
    );

endinterface

// File: rtl/ddr3_rr_pick.sv
// Rotating-priority encoder: searches ptr+1 .. ptr+PORTS (mod PORTS) and
// returns the first set mask bit as one-hot and as an index.
module ddr3_rr_pick
    import ddr3_arb_pkg::*;
#(
    parameter int PORTS = 4,
    localparam int IW   = calc_psb(PORTS) + 1
) (
    input  logic [PORTS-1:0] mask,
    input  logic [IW-1:0]    ptr,
    output logic             any,
    output logic [PORTS-1:0] onehot,
    output logic [IW-1:0]    idx
);

    // Priority search, nearest port after the pointer wins.
    always_comb begin
        any    = 1'b0;
        onehot = {PORTS{1'b0}};
        idx    = {IW{1'b0}};
        for (int k = 1; k <= PORTS; k++) begin
            for (int p = 0; p < PORTS; p++) begin
                if (!any && mask[p] && (p == (int'(ptr) + k) % PORTS)) begin
                    any       = 1'b1;
                    onehot[p] = 1'b1;
                    idx       = IW'(p);
                end else begin
                end
            end
        end
    end

endmodule

// File: rtl/ddr3_req_arbiter.sv
// Arbitrates PORTS request channels onto the single ddr3_fsm request interface,
// one transaction in flight. Optional build macro: ARB_AGE_LIMIT_EN (write aging).
module ddr3_req_arbiter
    import ddr3_arb_pkg::*;
#(
    parameter int PORTS        = 4,
    parameter int DDR_ROW_BITS = 15,
    parameter int DDR_COL_BITS = 10,
    parameter int AXI_ID_WIDTH = 4,
    parameter int RD_PRIORITY  = 0,
    parameter int AGE_LIMIT    = 8
) (
    input  logic              clock,
    input  logic              reset,
    ddr3_req_arbiter_if.slave bus
);
    localparam int PSB          = calc_psb(PORTS);
    localparam int ADR_W        = DDR_ROW_BITS + DDR_COL_BITS;
    localparam int MEM_ID_WIDTH = calc_mem_id_width(PORTS, AXI_ID_WIDTH);
    localparam int PTR_RST      = PORTS - 1;

    arb_state_e              state_r, state_nxt_s;
    logic [PSB:0]            ptr_r, ptr_nxt_s;
    logic [PORTS-1:0]        win_oh_r, win_oh_nxt_s;
    logic                    wrreq_r, wrreq_nxt_s;
    logic                    rdreq_r, rdreq_nxt_s;
    logic [MEM_ID_WIDTH-1:0] tid_r, tid_nxt_s;
    logic [ADR_W-1:0]        adr_r, adr_nxt_s;
    logic [PORTS-1:0]        ack_r, ack_nxt_s;
    logic [PORTS-1:0]        err_r, err_nxt_s;

    logic [PORTS-1:0]        rd_mask_s, wr_mask_s, pick_mask_s;
    logic [PORTS-1:0]        oh_a_s, oh_w_s, sel_oh_s;
    logic [PSB:0]            idx_a_s, idx_w_s, sel_idx_s;
    logic                    any_a_s, any_w_s, use_w_s, force_wr_s;
    logic                    grant_s, wr_sel_s, done_s, err_hit_s;
    logic [AXI_ID_WIDTH-1:0] tid_sel_s;
    logic [ADR_W-1:0]        adr_sel_s;

    assign rd_mask_s   = bus.req_valid_i & ~bus.req_write_i;
    assign wr_mask_s   = bus.req_valid_i & bus.req_write_i;
    assign pick_mask_s = (RD_PRIORITY != 0) ? rd_mask_s : bus.req_valid_i;

    ddr3_rr_pick #(.PORTS(PORTS)) u_pick_all (
        .mask(pick_mask_s), .ptr(ptr_r), .any(any_a_s), .onehot(oh_a_s), .idx(idx_a_s)
    );

    ddr3_rr_pick #(.PORTS(PORTS)) u_pick_wr (
        .mask(wr_mask_s), .ptr(ptr_r), .any(any_w_s), .onehot(oh_w_s), .idx(idx_w_s)
    );

`ifdef ARB_AGE_LIMIT_EN
    localparam int AGE_W = $clog2(AGE_LIMIT + 1);
    logic [AGE_W-1:0] age_r;

    // Counts read grants made while a write is waiting; a write grant or no waiting write clears it.
    always_ff @(posedge clock) begin
        if (reset) begin
            age_r <= {AGE_W{1'b0}};
        end else if ((RD_PRIORITY == 0) || !any_w_s) begin
            age_r <= {AGE_W{1'b0}};
        end else if (grant_s && wr_sel_s) begin
            age_r <= {AGE_W{1'b0}};
        end else if (grant_s && (age_r < AGE_W'(AGE_LIMIT))) begin
            age_r <= age_r + AGE_W'(1);
        end else begin
            age_r <= age_r;
        end
    end

    assign force_wr_s = (RD_PRIORITY != 0) && any_w_s && (age_r >= AGE_W'(AGE_LIMIT));
`else
    assign force_wr_s = 1'b0;
`endif

    // In read-priority mode the write picker is used only when no read is pending.
    assign use_w_s   = force_wr_s || ((RD_PRIORITY != 0) && !any_a_s && any_w_s);
    assign sel_idx_s = use_w_s ? idx_w_s : idx_a_s;
    assign sel_oh_s  = use_w_s ? oh_w_s : oh_a_s;
    assign wr_sel_s  = |(sel_oh_s & bus.req_write_i);
    assign grant_s   = (state_r == ST_IDLE) && (any_a_s || any_w_s);
    assign done_s    = wrreq_r ? (bus.mem_wrack_i | bus.mem_wrerr_i)
                               : (bus.mem_rdack_i | bus.mem_rderr_i);
    assign err_hit_s = wrreq_r ? bus.mem_wrerr_i : bus.mem_rderr_i;

    // Mux out the winning port's tid and address.
    always_comb begin
        tid_sel_s = {AXI_ID_WIDTH{1'b0}};
        adr_sel_s = {ADR_W{1'b0}};
        for (int p = 0; p < PORTS; p++) begin
            if (sel_oh_s[p]) begin
                tid_sel_s = bus.req_tid_i[p*AXI_ID_WIDTH +: AXI_ID_WIDTH];
                adr_sel_s = bus.req_adr_i[p*ADR_W +: ADR_W];
            end else begin
            end
        end
    end

    // Next-state and next-output logic; completion pulses default low every cycle.
    always_comb begin
        state_nxt_s  = state_r;
        ptr_nxt_s    = ptr_r;
        win_oh_nxt_s = win_oh_r;
        wrreq_nxt_s  = wrreq_r;
        rdreq_nxt_s  = rdreq_r;
        tid_nxt_s    = tid_r;
        adr_nxt_s    = adr_r;
        ack_nxt_s    = {PORTS{1'b0}};
        err_nxt_s    = {PORTS{1'b0}};
        case (state_r)
            ST_IDLE: begin
                if (grant_s) begin
                    state_nxt_s  = ST_BUSY;
                    ptr_nxt_s    = sel_idx_s;
                    win_oh_nxt_s = sel_oh_s;
                    wrreq_nxt_s  = wr_sel_s;
                    rdreq_nxt_s  = !wr_sel_s;
                    tid_nxt_s    = MEM_ID_WIDTH'(pack_tid(32'(sel_idx_s), 32'(tid_sel_s), AXI_ID_WIDTH));
                    adr_nxt_s    = adr_sel_s;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (done_s) begin
                    state_nxt_s = ST_DONE;
                    wrreq_nxt_s = 1'b0;
                    rdreq_nxt_s = 1'b0;
                    if (err_hit_s) begin
                        err_nxt_s = win_oh_r;
                    end else begin
                        ack_nxt_s = win_oh_r;
                    end
                end else begin
                    state_nxt_s = ST_BUSY;
                end
            end
            ST_DONE: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
                wrreq_nxt_s = 1'b0;
                rdreq_nxt_s = 1'b0;
            end
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r  <= ST_IDLE;
            ptr_r    <= PTR_RST[PSB:0];
            win_oh_r <= {PORTS{1'b0}};
            wrreq_r  <= 1'b0;
            rdreq_r  <= 1'b0;
            tid_r    <= {MEM_ID_WIDTH{1'b0}};
            adr_r    <= {ADR_W{1'b0}};
            ack_r    <= {PORTS{1'b0}};
            err_r    <= {PORTS{1'b0}};
        end else begin
            state_r  <= state_nxt_s;
            ptr_r    <= ptr_nxt_s;
            win_oh_r <= win_oh_nxt_s;
            wrreq_r  <= wrreq_nxt_s;
            rdreq_r  <= rdreq_nxt_s;
            tid_r    <= tid_nxt_s;
            adr_r    <= adr_nxt_s;
            ack_r    <= ack_nxt_s;
            err_r    <= err_nxt_s;
        end
    end

    assign bus.req_ack_o   = ack_r;
    assign bus.req_err_o   = err_r;
    assign bus.mem_wrreq_o = wrreq_r;
    assign bus.mem_rdreq_o = rdreq_r;
    assign bus.mem_wrtid_o = tid_r;
    assign bus.mem_rdtid_o = tid_r;
    assign bus.mem_wradr_o = adr_r;
    assign bus.mem_rdadr_o = adr_r;

endmodule

// File: tb/tb_ddr3_req_arbiter.sv
// Self-checking bench for ddr3_req_arbiter: a round-robin instance and a
// read-priority instance (AGE_LIMIT=4), selected by 'sel', against a behavioural model.
`timescale 1ns/1ps
module tb_ddr3_req_arbiter;
    localparam int P  = 4;
    localparam int IW = 4;
    localparam int AW = 25;
    localparam int AGE_LIM = 4;
`ifdef ARB_AGE_LIMIT_EN
    localparam bit AGE_EN = 1'b1;
`else
    localparam bit AGE_EN = 1'b0;
`endif

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic sel   = 1'b0;
    logic [P-1:0]    req_valid = '0, req_write = '0;
    logic [P*IW-1:0] req_tid = '0;
    logic [P*AW-1:0] req_adr = '0;
    logic mem_wrack = 1'b0, mem_wrerr = 1'b0, mem_rdack = 1'b0, mem_rderr = 1'b0;
    logic [P-1:0] req_ack, req_err;
    logic mem_wrreq, mem_rdreq;
    logic [5:0] wrtid, rdtid;
    logic [AW-1:0] wradr, rdadr;

    int n_tests = 0;
    int n_fail  = 0;
    int ptr_m   = P - 1;
    int age_m   = 0;
    logic [1:0] obs_port;
    logic [5:0] obs_tid;
    bit obs_wr;

    always #5 clock = ~clock;

    ddr3_req_arbiter_if #(.PORTS(P), .DDR_ROW_BITS(15), .DDR_COL_BITS(10), .AXI_ID_WIDTH(IW)) if0 ();
    ddr3_req_arbiter_if #(.PORTS(P), .DDR_ROW_BITS(15), .DDR_COL_BITS(10), .AXI_ID_WIDTH(IW)) if1 ();

    ddr3_req_arbiter #(.PORTS(P), .DDR_ROW_BITS(15), .DDR_COL_BITS(10), .AXI_ID_WIDTH(IW),
                       .RD_PRIORITY(0), .AGE_LIMIT(AGE_LIM))
        dut_rr (.clock(clock), .reset(reset), .bus(if0));
    ddr3_req_arbiter #(.PORTS(P), .DDR_ROW_BITS(15), .DDR_COL_BITS(10), .AXI_ID_WIDTH(IW),
                       .RD_PRIORITY(1), .AGE_LIMIT(AGE_LIM))
        dut_rp (.clock(clock), .reset(reset), .bus(if1));

    assign if0.req_valid_i = sel ? 4'b0 : req_valid;
    assign if1.req_valid_i = sel ? req_valid : 4'b0;
    assign if0.req_write_i = req_write;
    assign if1.req_write_i = req_write;
    assign if0.req_tid_i   = req_tid;
    assign if1.req_tid_i   = req_tid;
    assign if0.req_adr_i   = req_adr;
    assign if1.req_adr_i   = req_adr;
    assign if0.mem_wrack_i = sel ? 1'b0 : mem_wrack;
    assign if1.mem_wrack_i = sel ? mem_wrack : 1'b0;
    assign if0.mem_wrerr_i = sel ? 1'b0 : mem_wrerr;
    assign if1.mem_wrerr_i = sel ? mem_wrerr : 1'b0;
    assign if0.mem_rdack_i = sel ? 1'b0 : mem_rdack;
    assign if1.mem_rdack_i = sel ? mem_rdack : 1'b0;
    assign if0.mem_rderr_i = sel ? 1'b0 : mem_rderr;
    assign if1.mem_rderr_i = sel ? mem_rderr : 1'b0;

    assign req_ack   = sel ? if1.req_ack_o   : if0.req_ack_o;
    assign req_err   = sel ? if1.req_err_o   : if0.req_err_o;
    assign mem_wrreq = sel ? if1.mem_wrreq_o : if0.mem_wrreq_o;
    assign mem_rdreq = sel ? if1.mem_rdreq_o : if0.mem_rdreq_o;
    assign wrtid     = sel ? if1.mem_wrtid_o : if0.mem_wrtid_o;
    assign rdtid     = sel ? if1.mem_rdtid_o : if0.mem_rdtid_o;
    assign wradr     = sel ? if1.mem_wradr_o : if0.mem_wradr_o;
    assign rdadr     = sel ? if1.mem_rdadr_o : if0.mem_rdadr_o;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // First set bit of m after position 'last', wrapping around.
    function automatic int rr_first(input logic [P-1:0] m, input int last);
        for (int k = 1; k <= P; k++) begin
            if (m[(last + k) % P]) return (last + k) % P;
        end
        return -1;
    endfunction

    function automatic int model_winner();
        logic [P-1:0] rd, wr;
        rd = req_valid & ~req_write;
        wr = req_valid & req_write;
        if (!sel) return rr_first(req_valid, ptr_m);
        if (AGE_EN && age_m >= AGE_LIM && wr != 4'b0) return rr_first(wr, ptr_m);
        if (rd != 4'b0) return rr_first(rd, ptr_m);
        return rr_first(wr, ptr_m);
    endfunction

    task automatic do_reset();
        reset = 1'b1;
        req_valid = 4'b0; req_write = 4'b0;
        mem_wrack = 1'b0; mem_wrerr = 1'b0; mem_rdack = 1'b0; mem_rderr = 1'b0;
        step(); step();
        reset = 1'b0;
        ptr_m = P - 1;
        age_m = 0;
    endtask

    task automatic set_port(input int p, input bit wr, input logic [3:0] tid, input logic [24:0] adr);
        req_valid[p] = 1'b1;
        req_write[p] = wr;
        req_tid[p*IW +: IW] = tid;
        req_adr[p*AW +: AW] = adr;
    endtask

    // One full transaction from the current IDLE point: grant, hold for lat cycles, completion, DONE.
    task automatic run_txn(input int lat, input bit use_err, input bit stray);
        int w;
        bit exp_wr, wr_pend;
        logic [5:0] exp_tid;
        logic [24:0] exp_adr, got_adr;
        logic [3:0] exp_oh;
        w = model_winner();
        if (w < 0) w = 0;
        exp_wr  = req_write[w];
        exp_tid = {2'(w), req_tid[w*IW +: IW]};
        exp_adr = req_adr[w*AW +: AW];
        exp_oh  = 4'b0001 << w;
        wr_pend = (req_valid & req_write) != 4'b0;
        step();
        if (!wr_pend || exp_wr) age_m = 0;
        else if (age_m < AGE_LIM) age_m++;
        ptr_m   = w;
        obs_wr  = mem_wrreq;
        obs_tid = mem_wrreq ? wrtid : rdtid;
        obs_port = obs_tid[5:4];
        got_adr = mem_wrreq ? wradr : rdadr;
        n_tests++;
        if ({mem_wrreq, mem_rdreq} !== {exp_wr, !exp_wr}) begin
            n_fail++;
            $display("FAIL grant_type: got wr=%b rd=%b want wr=%b", mem_wrreq, mem_rdreq, exp_wr);
        end
        n_tests++;
        if (obs_tid !== exp_tid) begin
            n_fail++;
            $display("FAIL grant_tid: got %h want %h", obs_tid, exp_tid);
        end
        n_tests++;
        if (got_adr !== exp_adr) begin
            n_fail++;
            $display("FAIL grant_adr: got %h want %h", got_adr, exp_adr);
        end
        for (int i = 0; i < lat; i++) begin
            if (stray && i == 0) begin
                if (exp_wr) mem_rdack = 1'b1;
                else mem_wrack = 1'b1;
            end
            step();
            mem_rdack = 1'b0;
            mem_wrack = 1'b0;
            n_tests++;
            if ({mem_wrreq, mem_rdreq, req_ack, req_err} !== {exp_wr, !exp_wr, 8'h00}) begin
                n_fail++;
                $display("FAIL busy_hold: got wr=%b rd=%b ack=%b err=%b want wr=%b no pulse",
                         mem_wrreq, mem_rdreq, req_ack, req_err, exp_wr);
            end
        end
        if (exp_wr) begin
            mem_wrerr = use_err;
            mem_wrack = !use_err || ($urandom_range(0, 1) == 1);
        end else begin
            mem_rderr = use_err;
            mem_rdack = !use_err || ($urandom_range(0, 1) == 1);
        end
        step();
        mem_wrack = 1'b0; mem_wrerr = 1'b0; mem_rdack = 1'b0; mem_rderr = 1'b0;
        n_tests++;
        if (req_ack !== (use_err ? 4'b0 : exp_oh) || req_err !== (use_err ? exp_oh : 4'b0)) begin
            n_fail++;
            $display("FAIL done_pulse: got ack=%b err=%b want ack=%b err=%b", req_ack, req_err,
                     use_err ? 4'b0 : exp_oh, use_err ? exp_oh : 4'b0);
        end
        n_tests++;
        if ({mem_wrreq, mem_rdreq} !== 2'b00) begin
            n_fail++;
            $display("FAIL req_drop: got wr=%b rd=%b want 00", mem_wrreq, mem_rdreq);
        end
        req_valid[w] = 1'b0;
        step();
        n_tests++;
        if ({req_ack, req_err} !== 8'h00) begin
            n_fail++;
            $display("FAIL pulse_width: got ack=%b err=%b want 0", req_ack, req_err);
        end
    endtask

    task automatic check_idle_outputs(input string name);
        n_tests++;
        if ({req_ack, req_err, mem_wrreq, mem_rdreq, wrtid, rdtid, wradr, rdadr} !== 72'h0) begin
            n_fail++;
            $display("FAIL %s: got ack=%b err=%b wr=%b rd=%b tid=%h/%h adr=%h/%h want all 0", name,
                     req_ack, req_err, mem_wrreq, mem_rdreq, wrtid, rdtid, wradr, rdadr);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step(); step();
        sel = 1'b0; #1;
        check_idle_outputs("reset_rr");
        sel = 1'b1; #1;
        check_idle_outputs("reset_rp");
        sel = 1'b0;
        do_reset();
    endtask

    task automatic test_single_write();
        sel = 1'b0; do_reset();
        set_port(0, 1'b1, 4'd3, 25'h0012345);
        run_txn(4, 1'b0, 1'b0);
        n_tests++;
        if (obs_tid !== 6'b00_0011) begin
            n_fail++;
            $display("FAIL t1_wrtid: got %h want 03", obs_tid);
        end
    endtask

    task automatic test_back_to_back();
        sel = 1'b0; do_reset();
        for (int p = 0; p < P; p++) set_port(p, 1'b0, 4'($urandom), 25'($urandom));
        for (int g = 0; g < 5; g++) begin
            run_txn(0, 1'b0, 1'b0);
            n_tests++;
            if (int'(obs_port) != g % P) begin
                n_fail++;
                $display("FAIL rr_order[%0d]: got port %0d want %0d", g, obs_port, g % P);
            end
            req_valid = 4'b1111;
        end
    endtask

    task automatic test_rd_priority();
        int first_wr, exp_first;
        sel = 1'b1; do_reset();
        set_port(0, 1'b0, 4'd1, 25'h0000100);
        set_port(1, 1'b1, 4'd2, 25'h0000200);
        set_port(2, 1'b0, 4'd3, 25'h0000300);
        first_wr  = -1;
        exp_first = AGE_EN ? AGE_LIM : -1;
        for (int g = 0; g < 10; g++) begin
            run_txn(0, 1'b0, 1'b0);
            if (obs_wr && first_wr < 0) first_wr = g;
            req_valid = 4'b0111;
        end
        n_tests++;
        if (first_wr != exp_first) begin
            n_fail++;
            $display("FAIL rd_priority_first_write: got grant %0d want %0d", first_wr, exp_first);
        end
    endtask

    task automatic test_error();
        sel = 1'b0; do_reset();
        set_port(2, 1'b0, 4'd9, 25'h1abcdef);
        run_txn(1, 1'b1, 1'b0);
    endtask

    task automatic test_reset_mid();
        sel = 1'b0; do_reset();
        set_port(3, 1'b1, 4'd5, 25'h0055555);
        step();
        n_tests++;
        if (mem_wrreq !== 1'b1) begin
            n_fail++;
            $display("FAIL t5_granted: got wrreq=%b want 1", mem_wrreq);
        end
        reset = 1'b1;
        step();
        check_idle_outputs("t5_reset_mid");
        reset = 1'b0;
        ptr_m = P - 1;
        age_m = 0;
        for (int p = 0; p < P; p++) set_port(p, p[0], 4'($urandom), 25'($urandom));
        run_txn(1, 1'b0, 1'b0);
        n_tests++;
        if (obs_port !== 2'd0) begin
            n_fail++;
            $display("FAIL t5_first_after_reset: got port %0d want 0", obs_port);
        end
        req_valid = 4'b0;
    endtask

    task automatic test_stray_ack();
        sel = 1'b0; do_reset();
        set_port(1, 1'b1, 4'd7, 25'h0777777);
        run_txn(2, 1'b0, 1'b1);
    endtask

    task automatic test_random(input bit s);
        int q;
        sel = s; do_reset();
        for (int t = 0; t < 40; t++) begin
            for (int p = 0; p < P; p++) begin
                if (req_valid[p]) begin
                    if ($urandom_range(0, 7) == 0) req_valid[p] = 1'b0;
                end else if ($urandom_range(0, 1) == 1) begin
                    set_port(p, 1'($urandom_range(0, 1)), 4'($urandom), 25'($urandom));
                end
            end
            if (req_valid == 4'b0) begin
                q = $urandom_range(0, P - 1);
                req_valid[q] = 1'b1;
            end
            run_txn($urandom_range(0, 3), $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0);
        end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_back_to_back();
        test_rd_priority();
        test_error();
        test_reset_mid();
        test_stray_ack();
        test_random(1'b0);
        test_random(1'b1);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
